// File: rtl/mux_scan_ctrl.sv
// Scans a downstream 4:1 mux through channels 0..3, holding each select code for DWELL cycles
// and sampling the returned y on the last cycle of each window into a 4-bit frame.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic [3:0] frame,
  output logic       frame_valid,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DcLast = CNT_W'(DWELL - 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e           state_q, state_d;
  logic             prime_q, prime_d;
  logic [1:0]       ch_q, ch_d;
  logic [CNT_W-1:0] dc_q, dc_d;
  logic [2:0]       shadow_q, shadow_d;
  logic [3:0]       frame_q, frame_d;
  logic             fv_q, fv_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      prime_q  <= 1'b0;
      ch_q     <= 2'd0;
      dc_q     <= '0;
      shadow_q <= 3'b000;
      frame_q  <= 4'b0000;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      prime_q  <= prime_d;
      ch_q     <= ch_d;
      dc_q     <= dc_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
    end
  end

  // A frame started from IDLE spends one lead-in cycle on channel 0 before dwell counting
  // begins; back-to-back continuous frames skip it.
  always_comb begin
    state_d  = state_q;
    prime_d  = prime_q;
    ch_d     = ch_q;
    dc_d     = dc_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    fv_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          prime_d = 1'b1;
          ch_d    = 2'd0;
          dc_d    = '0;
        end
      end
      StScan: begin
        if (prime_q) begin
          prime_d = 1'b0;
        end else if (dc_q == DcLast) begin
          dc_d = '0;
          ch_d = ch_q + 2'd1;
          unique case (ch_q)
            2'd0: shadow_d[0] = y;
            2'd1: shadow_d[1] = y;
            2'd2: shadow_d[2] = y;
            2'd3: begin
              frame_d = {y, shadow_q};
              fv_d    = 1'b1;
              if (!cont) state_d = StIdle;
            end
            default: ;
          endcase
        end else begin
          dc_d = dc_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ch_q is zero whenever the block is idle, so the select needs no extra gating.
  assign s0          = ch_q[0];
  assign s1          = ch_q[1];
  assign busy        = (state_q == StScan);
  assign frame       = frame_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: DWELL=4 and DWELL=1 instances checked every cycle against a
// timeline model, plus directed scenarios with hand-computed expectations.
module tb_mux_scan_ctrl;

  localparam int D0 = 4;
  localparam int D1 = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       start = 2'b00;
  logic [1:0]       cont = 2'b00;
  logic [1:0]       y;
  logic [1:0]       s0, s1, fv, busy;
  logic [1:0][3:0]  frame;
  logic [1:0][3:0]  mux_in = '0;
  logic [1:0]       nz = 2'b00;
  logic             noise_en = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  // Timeline model: k = cycles since the start edge (0 = lead-in cycle), idle when not scanning.
  int         k [2] = '{0, 0};
  bit         idle [2] = '{1'b1, 1'b1};
  logic [3:0] cap [2] = '{4'b0, 4'b0};
  logic [3:0] m_frame [2] = '{4'b0, 4'b0};
  bit         m_fv [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  assign y[0] = mux_in[0][{s1[0], s0[0]}] ^ nz[0];
  assign y[1] = mux_in[1][{s1[1], s0[1]}] ^ nz[1];

  mux_scan_ctrl #(.DWELL(D0), .CNT_W(8)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .cont(cont[0]), .y(y[0]),
    .s0(s0[0]), .s1(s1[0]), .frame(frame[0]), .frame_valid(fv[0]), .busy(busy[0])
  );

  mux_scan_ctrl #(.DWELL(D1), .CNT_W(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .cont(cont[1]), .y(y[1]),
    .s0(s0[1]), .s1(s1[1]), .frame(frame[1]), .frame_valid(fv[1]), .busy(busy[1])
  );

  function automatic int dwell(input int j);
    return (j == 0) ? D0 : D1;
  endfunction

  function automatic int exp_sel(input int j);
    if (idle[j] || k[j] == 0) return 0;
    return (k[j] - 1) / dwell(j);
  endfunction

  function automatic bit last_cycle(input int j);
    return !idle[j] && k[j] >= 1 && ((k[j] - 1) % dwell(j)) == dwell(j) - 1;
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    int d;
    int idx;
    for (int j = 0; j < 2; j++) begin
      d = dwell(j);
      if (!rst_n) begin
        idle[j] = 1'b1; k[j] = 0; cap[j] = 4'b0; m_frame[j] = 4'b0; m_fv[j] = 1'b0;
      end else begin
        m_fv[j] = 1'b0;
        if (idle[j]) begin
          if (start[j]) begin idle[j] = 1'b0; k[j] = 0; end
        end else if (k[j] == 0) begin
          k[j] = 1;
        end else begin
          idx = k[j] - 1;
          if (idx % d == d - 1) begin
            cap[j][idx / d] = mux_in[j][idx / d];
            if (idx / d == 3) begin
              m_frame[j] = cap[j];
              m_fv[j]    = 1'b1;
              if (cont[j]) k[j] = 1;
              else idle[j] = 1'b1;
            end else begin
              k[j] = k[j] + 1;
            end
          end else begin
            k[j] = k[j] + 1;
          end
        end
      end
    end
  end

  // y wiggles on every non-sampling cycle when noise is enabled.
  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (noise_en && !last_cycle(j)) nz[j] = ~nz[j];
      else nz[j] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      check($sformatf("sel[%0d]", j), int'({s1[j], s0[j]}), exp_sel(j));
      check($sformatf("busy[%0d]", j), int'(busy[j]), int'(!idle[j]));
      check($sformatf("frame[%0d]", j), int'(frame[j]), int'(m_frame[j]));
      check($sformatf("frame_valid[%0d]", j), int'(fv[j]), int'(m_fv[j]));
    end
  end

  task automatic run_frame(input int j, input bit hold, input int limit, output int n,
                           output bit dropped);
    start[j] = 1'b1;
    n = 0;
    dropped = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (!hold) start[j] = 1'b0;
      if (fv[j]) begin n = c; break; end
      if (!busy[j]) dropped = 1'b1;
    end
  endtask

  task automatic wait_fv(input int j, input int limit, output int n, output bit dropped);
    n = 0;
    dropped = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (fv[j]) begin n = c; break; end
      if (!busy[j]) dropped = 1'b1;
    end
  endtask

  initial begin
    int n;
    int cnt;
    bit dr;
    int sel_log [19];
    int busy_log [19];
    int fv_first;

    #1 rst_n = 1'b0;
    #1;
    check("reset_frame", int'(frame[0]), 0);
    check("reset_busy", int'(busy[0]), 0);
    check("reset_sel", int'({s1[0], s0[0]}), 0);
    check("reset_fv", int'(fv[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, DWELL=4, i0..i3 = 1,0,1,0.
    mux_in[0] = 4'b0101;
    cont[0]   = 1'b0;
    start[0]  = 1'b1;
    fv_first  = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      sel_log[c]  = int'({s1[0], s0[0]});
      busy_log[c] = int'(busy[0]);
      if (fv[0] && fv_first == 0) fv_first = c;
    end
    check("t1_latency_edges", fv_first - 1, 17);
    check("t1_sel_n5", sel_log[5], 0);
    check("t1_sel_n6", sel_log[6], 1);
    check("t1_sel_n10", sel_log[10], 2);
    check("t1_sel_n14", sel_log[14], 3);
    check("t1_sel_n17", sel_log[17], 3);
    check("t1_busy_n1", busy_log[1], 1);
    check("t1_busy_after", busy_log[18], 0);
    check("t1_sel_after", sel_log[18], 0);
    check("t1_frame", int'(frame[0]), 4'b0101);
    repeat (3) @(negedge clk);

    // Continuous mode: second frame follows 16 cycles later with new inputs.
    cont[0] = 1'b1;
    run_frame(0, 1'b0, 40, n, dr);
    check("t2_first_latency", n - 1, 17);
    check("t2_first_frame", int'(frame[0]), 4'b0101);
    mux_in[0] = 4'b0110;
    n = 0;
    dr = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 8) cont[0] = 1'b0;
      if (fv[0]) begin n = c; break; end
      if (!busy[0]) dr = 1'b1;
    end
    check("t2_gap", n, 16);
    check("t2_second_frame", int'(frame[0]), 4'b0110);
    check("t2_busy_dropped", int'(dr), 0);
    check("t2_idle_after", int'(busy[0]), 0);
    repeat (3) @(negedge clk);

    // y toggles except on the sampling cycle.
    noise_en  = 1'b1;
    mux_in[0] = 4'b1010;
    run_frame(0, 1'b0, 40, n, dr);
    check("t3_latency", n - 1, 17);
    check("t3_frame", int'(frame[0]), 4'b1010);
    noise_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of channel 2.
    mux_in[0] = 4'b0011;
    start[0]  = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    check("t4_sel_before_reset", int'({s1[0], s0[0]}), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_sel", int'({s1[0], s0[0]}), 0);
    check("t4_rst_busy", int'(busy[0]), 0);
    check("t4_rst_frame", int'(frame[0]), 0);
    check("t4_rst_fv", int'(fv[0]), 0);
    cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (fv[0]) cnt++;
    end
    check("t4_no_fv", cnt, 0);
    rst_n = 1'b1;
    run_frame(0, 1'b0, 40, n, dr);
    check("t4_restart_latency", n - 1, 17);
    check("t4_restart_frame", int'(frame[0]), 4'b0011);
    repeat (3) @(negedge clk);

    // Start pulses while busy are ignored.
    mux_in[0] = 4'b1001;
    start[0]  = 1'b1;
    cnt = 0;
    fv_first = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start[0] = (c == 5 || c == 12 || c == 17);
      if (fv[0]) begin
        cnt++;
        if (fv_first == 0) fv_first = c;
      end
    end
    check("t5_fv_count", cnt, 1);
    check("t5_latency", fv_first - 1, 17);
    check("t5_frame", int'(frame[0]), 4'b1001);

    // DWELL=1, start held high, cont=0: one frame every 6 cycles.
    mux_in[1] = 4'b1101;
    cont[1]   = 1'b0;
    run_frame(1, 1'b1, 20, n, dr);
    check("t6_first", n, 6);
    check("t6_frame", int'(frame[1]), 4'b1101);
    wait_fv(1, 20, n, dr);
    check("t6_period_a", n, 6);
    mux_in[1] = 4'b0110;
    wait_fv(1, 20, n, dr);
    check("t6_period_b", n, 6);
    check("t6_frame_b", int'(frame[1]), 4'b0110);
    start[1] = 1'b0;
    repeat (8) @(negedge clk);

    // Randomized traffic on both instances, checked by the per-cycle compare.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      for (int j = 0; j < 2; j++) begin
        start[j] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 7) == 0) cont[j] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) mux_in[j] = 4'($urandom);
      end
      if (c % 500 == 0) noise_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) begin
        #3 rst_n = 1'b0;
      end
    end
    rst_n = 1'b1;
    start = 2'b00;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
